// File: rtl/rv_decode_exec_unit.sv
// Decode, control generation and ALU slice of a multicycle RV32I-subset datapath.
// Optional feature: define OPT_BNE_EN to add bne (branch funct3 001) support.
module rv_decode_exec_unit #(
  parameter logic [3:0] ST_DECODE = 4'b0001,
  parameter logic [3:0] ST_EXEC   = 4'b0101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  estado,
  input  logic [31:0] instrucao,
  input  logic [31:0] ler_dados1,
  input  logic [31:0] ler_dados2,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] imediato,
  output logic        negativo,
  output logic [2:0]  tipo,
  output logic        regiwrite,
  output logic        memwrite,
  output logic        memread,
  output logic        memtoreg,
  output logic        alusrc,
  output logic        branch,
  output logic [3:0]  alucontrol,
  output logic        is_lb,
  output logic        is_sb,
  output logic        aluresult1,
  output logic [31:0] aluresult2,
  output logic        pcsrc
);

  localparam logic [2:0] TipoR      = 3'd0;
  localparam logic [2:0] TipoI      = 3'd1;
  localparam logic [2:0] TipoLoad   = 3'd2;
  localparam logic [2:0] TipoStore  = 3'd3;
  localparam logic [2:0] TipoBranch = 3'd4;
  localparam logic [2:0] TipoInv    = 3'd7;

  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluNone = 4'b1111;

  logic [6:0]  opcode_q, funct7_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q, tipo_q, tipo_d;
  logic [11:0] imediato_q, imediato_d;
  logic        negativo_q;
  logic [31:0] aluresult2_q, result;
  logic        aluresult1_q, pcsrc_q, pcsrc_d;
  logic [31:0] op_b;

  always_comb begin
    unique case (instrucao[6:0])
      7'b0110011: tipo_d = TipoR;
      7'b0010011: tipo_d = TipoI;
      7'b0000011: tipo_d = TipoLoad;
      7'b0100011: tipo_d = TipoStore;
      7'b1100011: tipo_d = TipoBranch;
      default:    tipo_d = TipoInv;
    endcase
  end

  always_comb begin
    imediato_d = 12'h000;
    unique case (tipo_d)
      TipoI, TipoLoad: imediato_d = instrucao[31:20];
      TipoStore:       imediato_d = {instrucao[31:25], instrucao[11:7]};
      TipoBranch:      imediato_d = {instrucao[31], instrucao[7], instrucao[30:25],
                                     instrucao[11:8]};
      default:         imediato_d = 12'h000;
    endcase
  end

  // Control is derived from the latched fields so it stays stable from EX onward.
  always_comb begin
    regiwrite  = 1'b0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    memtoreg   = 1'b0;
    alusrc     = 1'b0;
    branch     = 1'b0;
    is_lb      = 1'b0;
    is_sb      = 1'b0;
    alucontrol = AluNone;
    unique case (tipo_q)
      TipoR: begin
        regiwrite = 1'b1;
        if (funct3_q == 3'b000 && funct7_q == 7'b0100000)   alucontrol = AluSub;
        else if (funct3_q == 3'b000 && funct7_q == 7'd0)    alucontrol = AluAdd;
        else if (funct3_q == 3'b100)                        alucontrol = AluXor;
        else if (funct3_q == 3'b101 && funct7_q == 7'd0)    alucontrol = AluSrl;
      end
      TipoI: begin
        regiwrite = 1'b1;
        alusrc    = 1'b1;
        if (funct3_q == 3'b000) alucontrol = AluAdd;
      end
      TipoLoad: begin
        regiwrite  = 1'b1;
        memread    = 1'b1;
        memtoreg   = 1'b1;
        alusrc     = 1'b1;
        is_lb      = (funct3_q == 3'b000);
        alucontrol = AluAdd;
      end
      TipoStore: begin
        memwrite   = 1'b1;
        alusrc     = 1'b1;
        is_sb      = (funct3_q == 3'b000);
        alucontrol = AluAdd;
      end
      TipoBranch: begin
        branch = 1'b1;
        if (funct3_q == 3'b000) alucontrol = AluSub;
`ifdef OPT_BNE_EN
        if (funct3_q == 3'b001) alucontrol = AluSub;
`endif
      end
      default: ;
    endcase
  end

  assign op_b = alusrc ? {{20{negativo_q}}, imediato_q} : ler_dados2;

  always_comb begin
    unique case (alucontrol)
      AluAdd:  result = ler_dados1 + op_b;
      AluSub:  result = ler_dados1 - op_b;
      AluXor:  result = ler_dados1 ^ op_b;
      AluSrl:  result = ler_dados1 >> op_b[4:0];
      default: result = 32'h0;
    endcase
  end

  // Unsupported branch funct3 decode to NONE and must never be taken.
  always_comb begin
`ifdef OPT_BNE_EN
    pcsrc_d = branch && (alucontrol == AluSub) &&
              ((funct3_q == 3'b001) ? (result != 32'h0) : (result == 32'h0));
`else
    pcsrc_d = branch && (alucontrol == AluSub) && (result == 32'h0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q     <= 7'd0;
      rd_q         <= 5'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      funct3_q     <= 3'd0;
      funct7_q     <= 7'd0;
      negativo_q   <= 1'b0;
      tipo_q       <= TipoInv;
      imediato_q   <= 12'h000;
      aluresult2_q <= 32'h0;
      aluresult1_q <= 1'b0;
      pcsrc_q      <= 1'b0;
    end else begin
      if (estado == ST_DECODE) begin
        opcode_q   <= instrucao[6:0];
        rd_q       <= instrucao[11:7];
        rs1_q      <= instrucao[19:15];
        rs2_q      <= instrucao[24:20];
        funct3_q   <= instrucao[14:12];
        funct7_q   <= instrucao[31:25];
        negativo_q <= instrucao[31];
        tipo_q     <= tipo_d;
        imediato_q <= imediato_d;
      end
      if (estado == ST_EXEC) begin
        aluresult2_q <= result;
        aluresult1_q <= (result == 32'h0);
        pcsrc_q      <= pcsrc_d;
      end
    end
  end

  assign opcode     = opcode_q;
  assign rd         = rd_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign funct3     = funct3_q;
  assign funct7     = funct7_q;
  assign negativo   = negativo_q;
  assign tipo       = tipo_q;
  assign imediato   = imediato_q;
  assign aluresult2 = aluresult2_q;
  assign aluresult1 = aluresult1_q;
  assign pcsrc      = pcsrc_q;

endmodule

// File: tb/tb_rv_decode_exec_unit.sv
// Directed self-checking bench for rv_decode_exec_unit (hand-computed expectations).
module tb_rv_decode_exec_unit;

  logic        clk, rst;
  logic [3:0]  estado;
  logic [31:0] instrucao, ler_dados1, ler_dados2;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, tipo;
  logic [11:0] imediato;
  logic        negativo, regiwrite, memwrite, memread, memtoreg, alusrc, branch;
  logic [3:0]  alucontrol;
  logic        is_lb, is_sb, aluresult1, pcsrc;
  logic [31:0] aluresult2;

  int total = 0;
  int bad   = 0;

  rv_decode_exec_unit dut (
    .clk(clk), .rst(rst), .estado(estado), .instrucao(instrucao),
    .ler_dados1(ler_dados1), .ler_dados2(ler_dados2),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imediato(imediato), .negativo(negativo), .tipo(tipo),
    .regiwrite(regiwrite), .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg),
    .alusrc(alusrc), .branch(branch), .alucontrol(alucontrol),
    .is_lb(is_lb), .is_sb(is_sb), .aluresult1(aluresult1), .aluresult2(aluresult2),
    .pcsrc(pcsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Latch ins in ID, then move to EX with a garbage instruction to prove the hold.
  task automatic decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    estado    = 4'b0001;
    instrucao = ins;
    @(posedge clk);
    #1;
    estado     = 4'b0010;
    instrucao  = 32'h0;
    ler_dados1 = a;
    ler_dados2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic execute();
    estado = 4'b0101;
    @(posedge clk);
    #1;
    estado = 4'b0000;
  endtask

  initial begin
    rst = 1'b0; estado = 4'b0000; instrucao = 32'h0; ler_dados1 = 32'h0; ler_dados2 = 32'h0;
    #12;
    chk("rst_tipo", {29'd0, tipo}, 32'd7);
    chk("rst_alucontrol", {28'd0, alucontrol}, 32'hF);
    rst = 1'b1;
    @(posedge clk); #1;

    // addi x1,x0,-5
    decode(32'hFFB00093, 32'h0, 32'h1234);
    chk("addi_tipo", {29'd0, tipo}, 32'd1);
    chk("addi_imm", {20'd0, imediato}, 32'hFFB);
    chk("addi_neg", {31'd0, negativo}, 32'd1);
    chk("addi_ctl", {28'd0, regiwrite, alusrc, memwrite, memread}, 32'b1100);
    chk("addi_rd", {27'd0, rd}, 32'd1);
    execute();
    chk("addi_res", aluresult2, 32'hFFFFFFFB);
    chk("addi_zero", {31'd0, aluresult1}, 32'd0);

    // sub x3,x1,x2
    decode(32'h402081B3, 32'd7, 32'd7);
    chk("sub_aluc", {28'd0, alucontrol}, 32'b0110);
    chk("sub_ctl", {30'd0, regiwrite, alusrc}, 32'b10);
    chk("sub_rs2", {27'd0, rs2}, 32'd2);
    chk("sub_f7", {25'd0, funct7}, 32'h20);
    execute();
    chk("sub_res", aluresult2, 32'h0);
    chk("sub_zero", {31'd0, aluresult1}, 32'd1);
    chk("sub_pcsrc", {31'd0, pcsrc}, 32'd0);

    // srl x3,x1,x2
    decode(32'h0020D1B3, 32'h80000000, 32'd4);
    chk("srl_aluc", {28'd0, alucontrol}, 32'b0101);
    execute();
    chk("srl_res", aluresult2, 32'h08000000);
    chk("srl_zero", {31'd0, aluresult1}, 32'd0);

    // add wraps around
    decode(32'h002081B3, 32'd5, 32'hFFFFFFFF);
    chk("add_aluc", {28'd0, alucontrol}, 32'b0010);
    execute();
    chk("add_res", aluresult2, 32'd4);

    // xor
    decode(32'h0020C1B3, 32'h0000F0F0, 32'h0000FF00);
    chk("xor_aluc", {28'd0, alucontrol}, 32'b0100);
    execute();
    chk("xor_res", aluresult2, 32'h00000FF0);

    // sw x2,8(x1)
    decode(32'h0020A423, 32'h10, 32'hDEAD);
    chk("sw_tipo", {29'd0, tipo}, 32'd3);
    chk("sw_imm", {20'd0, imediato}, 32'h008);
    chk("sw_ctl", {26'd0, memwrite, memread, regiwrite, alusrc, is_sb, is_lb}, 32'b100100);
    execute();
    chk("sw_res", aluresult2, 32'h18);

    // sb x2,8(x1)
    decode(32'h00208423, 32'h10, 32'hDEAD);
    chk("sb_is_sb", {31'd0, is_sb}, 32'd1);
    execute();
    chk("sb_res", aluresult2, 32'h18);

    // lw x5,-4(x1)
    decode(32'hFFC0A283, 32'h100, 32'h0);
    chk("lw_ctl", {26'd0, regiwrite, memread, memtoreg, alusrc, memwrite, is_lb}, 32'b111100);
    chk("lw_imm", {20'd0, imediato}, 32'hFFC);
    execute();
    chk("lw_res", aluresult2, 32'hFC);

    // lb x5,-4(x1)
    decode(32'hFFC08283, 32'h100, 32'h0);
    chk("lb_is_lb", {31'd0, is_lb}, 32'd1);

    // beq taken
    decode(32'h00208463, 32'd3, 32'd3);
    chk("beq_imm", {20'd0, imediato}, 32'h004);
    chk("beq_ctl", {28'd0, branch, alusrc, regiwrite, memwrite}, 32'b1000);
    chk("beq_aluc", {28'd0, alucontrol}, 32'b0110);
    execute();
    chk("beq_taken", {31'd0, pcsrc}, 32'd1);

    // beq not taken
    decode(32'h00208463, 32'd3, 32'd4);
    execute();
    chk("beq_nt", {31'd0, pcsrc}, 32'd0);

    // beq backward offset
    decode(32'hFE208EE3, 32'd9, 32'd9);
    chk("beqn_imm", {20'd0, imediato}, 32'hFFE);
    chk("beqn_neg", {31'd0, negativo}, 32'd1);
    execute();
    chk("beqn_taken", {31'd0, pcsrc}, 32'd1);

    // bne x1,x2
    decode(32'h00209463, 32'd3, 32'd4);
`ifdef OPT_BNE_EN
    chk("bne_aluc", {28'd0, alucontrol}, 32'b0110);
    execute();
    chk("bne_taken", {31'd0, pcsrc}, 32'd1);
`else
    chk("bne_aluc", {28'd0, alucontrol}, 32'b1111);
    execute();
    chk("bne_pcsrc", {31'd0, pcsrc}, 32'd0);
`endif

    // all-zero instruction
    decode(32'h00000000, 32'h55, 32'h66);
    chk("zero_tipo", {29'd0, tipo}, 32'd7);
    chk("zero_aluc", {28'd0, alucontrol}, 32'hF);
    chk("zero_ctl", {28'd0, regiwrite, memwrite, memread, branch}, 32'd0);
    chk("zero_imm", {20'd0, imediato}, 32'h0);
    execute();
    chk("zero_res", aluresult2, 32'h0);
    chk("zero_pcsrc", {31'd0, pcsrc}, 32'd0);

    // asynchronous reset mid-instruction
    decode(32'hFFB00093, 32'h7, 32'h0);
    execute();
    chk("pre_rst_res", aluresult2, 32'h2);
    decode(32'h00208463, 32'd3, 32'd3);
    execute();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tipo", {29'd0, tipo}, 32'd7);
    chk("arst_res", aluresult2, 32'h0);
    chk("arst_pcsrc", {31'd0, pcsrc}, 32'd0);
    chk("arst_ctl", {26'd0, regiwrite, memwrite, memread, memtoreg, alusrc, branch}, 32'd0);
    chk("arst_imm", {20'd0, imediato}, 32'h0);
    #3;
    rst = 1'b1;
    // Without a new decode, execute must still see invalid state.
    ler_dados1 = 32'h11;
    execute();
    chk("post_rst_res", aluresult2, 32'h0);
    chk("post_rst_tipo", {29'd0, tipo}, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
